uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
UART receive front end. It samples the asynchronous serial line `rx` and recovers 8N1 frames (LSB first). For each good frame it presents the byte on `data` with a one-cycle `ready` strobe. It sits directly upstream of the receiver output register, which latches `data` on `ready`. Bad stop bits are flagged on `frameErr`, and no byte is delivered for them.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit (integer, >=4). System default is overridden at top level, e.g. 5208 for 50 MHz / 9600 baud.
CNT_W, $clog2(CLKS_PER_BIT), bit-timer width. Derived; do not override.

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous active-low reset
rx  input  1  serial line, asynchronous, idle high
data  output  8  last correctly received byte
ready  output  1  one-cycle pulse: new byte valid on data
frameErr  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset, asynchronous, rst=0:
  - state=IDLE, bit timer=0, bit index=0, shift reg=0.
  - data=8'h00, ready=0, frameErr=0.
  - Both synchronizer flops = 1.
  - Takes effect immediately, including mid-frame: the frame is abandoned and nothing is reported.
- Input sync:
  - rx passes through 2 flops to give rx_s.
  - All decisions use rx_s only; this adds 2 cycles of latency.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - Timer held at 0.
  - rx_s==0 -> START.
- START:
  - Timer counts 0..(CLKS_PER_BIT-1)/2, i.e. to mid start bit.
  - At terminal count: rx_s==0 -> DATA with timer=0 and index=0; rx_s==1 -> IDLE (glitch rejected, no outputs).
- DATA:
  - Timer counts 0..CLKS_PER_BIT-1.
  - At terminal count, sample rx_s into shift reg bit[index] (LSB first), reset the timer, then index++.
  - After index 7 is sampled -> STOP.
- STOP:
  - Timer counts 0..CLKS_PER_BIT-1; at terminal count, sample rx_s.
  - rx_s==1: data<=shift reg, ready=1 for exactly that next cycle -> IDLE.
  - rx_s==0: frameErr=1 for one cycle, data unchanged, ready stays 0 -> BREAK.
- BREAK:
  - Wait for rx_s==1, then -> IDLE.
  - Prevents a held-low line (break) from being decoded as repeated 0x00 frames.
- Timing:
  - data changes only on the cycle ready rises, and is held stable until the next good frame.
  - ready and frameErr are never high in the same cycle.
  - ready rises 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1..2 cycles after the falling start edge on rx. For CLKS_PER_BIT=16 that is 154..155 cycles, with a fixed value per implementation (document it).
- Back-to-back frames:
  - After a good stop the block is in IDLE at mid stop bit, so a start edge at the next bit boundary is caught.
  - Zero idle bits between frames must work.
- Bit timing:
  - Sampling at bit centres tolerates +/-4% baud mismatch over a frame.
  - No resync on intermediate edges.
- Counter arithmetic is CNT_W unsigned, with no wrap: the timer always clears at terminal count.

Test Plan:
(CLKS_PER_BIT=16, clk period 10 ns, bit=160 ns)
1. Reset held low 500 ns, rx=1 -> data=8'h00, ready=0, frameErr=0 throughout. After release, 20 idle bits -> no ready.
2. Send 0x33 (start, 1,1,0,0,1,1,0,0, stop=1) -> exactly one 1-cycle ready pulse 154..155 clk after the start edge, data=8'h33, frameErr=0.
3. Send 0x33 then 0xBB with no idle gap -> two ready pulses ~160 clk apart: data=8'h33, then 8'hBB, with data stable between pulses.
4. rx low for 5 clk then high (glitch), then send 0xA5 -> no ready for the glitch; one ready with data=8'hA5.
5. Send 0x5A with stop bit=0, hold rx low 40 bit-times, then release and send 0x3C -> one frameErr pulse, no ready, data keeps previous value. No further events during the low period; next ready gives data=8'h3C.
6. Assert rst low at mid data bit 4 of 0xFF, release after 100 ns with rx idle -> no ready/frameErr. Outputs are 0 during reset; next frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART 8N1 receive front end: synchronizes rx, samples bit centres and delivers each good byte
// with a one-cycle ready strobe; a low stop bit raises frameErr and parks until the line idles.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       ready,
  output logic       frameErr
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  localparam logic [CNT_W-1:0] HalfLast = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] BitLast  = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_q;
  logic             rx_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic             frame_err_q, frame_err_d;

  // Reset to idle-high so a reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  // ready rises 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 2 cycles after the start edge
  // (155 for CLKS_PER_BIT=16).
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    ready_d     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (timer_q == HalfLast) begin
          timer_d = '0;
          idx_d   = 3'd0;
          state_d = rx_s ? StIdle : StData;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StData: begin
        if (timer_q == BitLast) begin
          shift_d[idx_q] = rx_s;
          timer_d        = '0;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StStop;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StStop: begin
        if (timer_q == BitLast) begin
          timer_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StBreak: begin
        timer_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: begin
        timer_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      ready_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data     = data_q;
  assign ready    = ready_q;
  assign frameErr = frame_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus random frames, scored against
// an event-level model (byte or error, and the cycle it must appear on).
module tb_uart_rx_core;

  localparam int C   = 16;
  localparam int Lat = 2 + (C - 1) / 2 + 9 * C + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       frame_err;

  always #5 clk = ~clk;

  uart_rx_core #(.CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .ready    (ready),
    .frameErr (frame_err)
  );

  typedef struct {
    int unsigned cyc;
    logic [7:0]  d;
    logic        err;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         act_q[$];
  int unsigned cyc       = 0;
  int          n_cmp     = 0;
  int          n_err     = 0;
  logic [7:0]  last_good = 8'h00;
  logic [7:0]  prev_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output event; also check data only moves with ready and never with frameErr.
  always @(negedge clk) begin
    if (rst) begin
      if (ready || frame_err) begin
        ev_t e;
        e.cyc = cyc;
        e.d   = data;
        e.err = frame_err;
        act_q.push_back(e);
      end
      if (ready) check("ready_ferr_excl", {31'd0, frame_err}, 32'd0);
      if (data !== prev_data) check("data_chg_needs_ready", {31'd0, ready}, 32'd1);
    end
    prev_data = data;
  end

  task automatic drive(input logic v, input int nbits);
    rx = v;
    repeat (nbits * C) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    ev_t e;
    e.cyc = cyc + Lat;
    e.err = !stop;
    e.d   = stop ? b : last_good;
    if (stop) last_good = b;
    exp_q.push_back(e);
    drive(1'b0, 1);
    for (int i = 0; i < 8; i++) drive(b[i], 1);
    drive(stop, 1);
  endtask

  task automatic drain(input string tag);
    int n;
    check({tag, "_count"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_err"}, {31'd0, act_q[i].err}, {31'd0, exp_q[i].err});
      check({tag, "_data"}, {24'd0, act_q[i].d}, {24'd0, exp_q[i].d});
      check({tag, "_cycle"}, act_q[i].cyc, exp_q[i].cyc);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // 1: reset held, outputs quiet; then idle line produces nothing
    repeat (50) begin
      @(negedge clk);
      check("rst_data", {24'd0, data}, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_ferr", {31'd0, frame_err}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 20);
    drain("idle");

    // 2: single frame
    send_frame(8'h33, 1'b1);
    drive(1'b1, 2);
    drain("single_33");

    // 3: back-to-back, no idle gap
    send_frame(8'h33, 1'b1);
    send_frame(8'hBB, 1'b1);
    drive(1'b1, 2);
    drain("b2b");

    // 4: short glitch rejected, then a real frame
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    drive(1'b1, 2);
    send_frame(8'hA5, 1'b1);
    drive(1'b1, 2);
    drain("glitch");

    // 5: bad stop, long break, recovery
    send_frame(8'h5A, 1'b0);
    drive(1'b0, 40);
    drive(1'b1, 2);
    send_frame(8'h3C, 1'b1);
    drive(1'b1, 2);
    drain("break");

    // 6: reset in the middle of data bit 4 of 0xFF
    drive(1'b0, 1);
    drive(1'b1, 4);
    repeat (C / 2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("midrst_data", {24'd0, data}, 32'd0);
      check("midrst_ready", {31'd0, ready}, 32'd0);
      check("midrst_ferr", {31'd0, frame_err}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b1;
    last_good = 8'h00;
    drive(1'b1, 2);
    drain("midrst_quiet");
    send_frame(8'h81, 1'b1);
    drive(1'b1, 2);
    drain("after_rst");

    // Random frames with occasional bad stops and random gaps
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      logic       stop;
      int         gap;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      gap  = $urandom_range(0, 2);
      if (!stop && gap == 0) gap = 1;
      send_frame(b, stop);
      if (gap > 0) drive(1'b1, gap);
    end
    drive(1'b1, 2);
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
